// File: rtl/rk11_pkg.sv
// RK11 controller shared definitions: register selects, function codes,
// error bit positions, sequencer states and disk geometry.
package rk11_pkg;

  // CPU register select codes
  localparam logic [2:0] SEL_RKDS = 3'd0;
  localparam logic [2:0] SEL_RKER = 3'd1;
  localparam logic [2:0] SEL_RKCS = 3'd2;
  localparam logic [2:0] SEL_RKWC = 3'd3;
  localparam logic [2:0] SEL_RKBA = 3'd4;
  localparam logic [2:0] SEL_RKDA = 3'd5;

  // RKCS.FUNC codes
  localparam logic [2:0] FN_CTRL_RESET  = 3'd0;
  localparam logic [2:0] FN_WRITE       = 3'd1;
  localparam logic [2:0] FN_READ        = 3'd2;
  localparam logic [2:0] FN_WRITE_CHECK = 3'd3;
  localparam logic [2:0] FN_SEEK        = 3'd4;
  localparam logic [2:0] FN_READ_CHECK  = 3'd5;
  localparam logic [2:0] FN_DRIVE_RESET = 3'd6;
  localparam logic [2:0] FN_WRITE_LOCK  = 3'd7;

  // RKER bit positions
  localparam int RKER_NXS = 5;
  localparam int RKER_NXC = 6;
  localparam int RKER_NXD = 7;
  localparam int RKER_WLO = 13;
  localparam int RKER_DRE = 15;

  // Geometry limits of an RK05 pack
  localparam int MAX_CYL  = 202;
  localparam int MAX_SECT = 11;

  // Command sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4
  } rk_state_e;

endpackage

// File: rtl/rk_chs_to_block.sv
// Combinational RKDA (drive/cylinder/surface/sector) to linear block address,
// plus the non-existent sector/cylinder/drive flags.
module rk_chs_to_block
  import rk11_pkg::*;
#(
  parameter int NUM_DRIVES     = 1,
  parameter int BLOCKS_PER_DRV = 4872
) (
  input  logic [15:0] rkda,
  output logic [23:0] block,
  output logic        nxs,
  output logic        nxc,
  output logic        nxd
);

  localparam logic [23:0] BPD     = 24'(BLOCKS_PER_DRV);
  localparam logic [3:0]  NDRV    = 4'(NUM_DRIVES);
  localparam logic [7:0]  CYL_MAX = 8'(MAX_CYL);
  localparam logic [3:0]  SEC_MAX = 4'(MAX_SECT);

  logic [2:0] drive;
  logic [7:0] cyl;
  logic       surf;
  logic [3:0] sect;

  assign drive = rkda[15:13];
  assign cyl   = rkda[12:5];
  assign surf  = rkda[4];
  assign sect  = rkda[3:0];

  // Track index is cyl*2+surf; twelve sectors per track
  assign block = 24'(drive) * BPD
               + (24'(cyl) * 24'd2 + 24'(surf)) * 24'd12
               + 24'(sect);

  assign nxs = sect > SEC_MAX;
  assign nxc = cyl > CYL_MAX;
  assign nxd = {1'b0, drive} >= NDRV;

endmodule

// File: rtl/rk11_ctrl.sv
// RK11 register file and command sequencer feeding the sdhd disk emulator.
// Optional macro RK_WRITE_PROTECT_EN adds per-drive write protect inputs.
//
// Disk request handshake: one request line (read/write/seek) is raised with a
// stable block address and held until sdhd drops i_disk_ready, acknowledging
// acceptance; the request then falls and completion is signalled by
// i_disk_ready rising again (or a nonzero i_sd_error / timeout).
module rk11_ctrl
  import rk11_pkg::*;
#(
  parameter int DMA_MSB        = 17,
  parameter int NUM_DRIVES     = 1,
  parameter int BLOCKS_PER_DRV = 4872,
  parameter int TIMEOUT_CYC    = 27_000_000,
  parameter int SECTOR_CYC     = 40_000
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [2:0]         i_reg_sel,
  input  logic               i_reg_wr,
  input  logic [15:0]        i_reg_wdata,
  output logic [15:0]        o_reg_rdata,
  output logic               o_irq,
  input  logic               i_irq_ack,
  output logic               o_disk_read,
  output logic               o_disk_write,
  output logic               o_disk_seek,
  output logic [23:0]        o_disk_block_address,
  output logic [DMA_MSB:0]   o_dma_start_address,
  output logic [15:0]        o_dma_wordcount,
  input  logic               i_disk_ready,
  input  logic [3:0]         i_sd_error,
`ifdef RK_WRITE_PROTECT_EN
  input  logic [NUM_DRIVES-1:0] i_write_protect,
`endif
  output rk_state_e          o_dbg_state
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SC_W = (SECTOR_CYC > 1) ? $clog2(SECTOR_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SECTOR_CYC - 1);

  rk_state_e   state;
  logic [2:0]  func;
  logic [1:0]  mex;
  logic        ide;
  logic        rdy;
  logic [15:0] rker;
  logic [15:0] rkwc;
  logic [15:0] rkba;
  logic [15:0] rkda;
  logic [2:0]  last_drive;
  logic [TO_W-1:0] to_cnt;
  logic [SC_W-1:0] sc_div;
  logic [3:0]  sector;

  logic [23:0] chs_block;
  logic        nxs, nxc, nxd;
  logic        wp_hit;
  logic        go_wr;
  logic [15:0] neg_wc;
  logic [17:0] dma_full;
  logic [17:0] dma_next;
  logic [15:0] rkcs_rd;
  logic [15:0] rkds_rd;

  rk_chs_to_block #(
    .NUM_DRIVES     (NUM_DRIVES),
    .BLOCKS_PER_DRV (BLOCKS_PER_DRV)
  ) u_chs (
    .rkda  (rkda),
    .block (chs_block),
    .nxs   (nxs),
    .nxc   (nxc),
    .nxd   (nxd)
  );

`ifdef RK_WRITE_PROTECT_EN
  logic [7:0] wp_ext;
  assign wp_ext = 8'(i_write_protect);
  assign wp_hit = (func == FN_WRITE) && wp_ext[rkda[15:13]];
`else
  assign wp_hit = 1'b0;
`endif

  assign go_wr    = i_reg_wr && (i_reg_sel == SEL_RKCS) && i_reg_wdata[0] && rdy;
  assign neg_wc   = 16'd0 - rkwc;
  assign dma_full = {mex, rkba};
  // Bytes moved = 2 * (-RKWC); the address wraps within 18 bits
  assign dma_next = dma_full + {1'b0, neg_wc, 1'b0};

  assign o_dma_start_address = dma_full[DMA_MSB:0];
  assign o_dma_wordcount     = rkwc;
  assign o_dbg_state         = state;

  assign rkcs_rd = {|rker, |rker[15:5], 6'b0, rdy, ide, mex, func, 1'b0};
  assign rkds_rd = {last_drive, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1,
                    (state == ST_IDLE), 2'b00, sector};

  // CPU read mux
  always_comb begin
    o_reg_rdata = '0;
    case (i_reg_sel)
      SEL_RKDS: o_reg_rdata = rkds_rd;
      SEL_RKER: o_reg_rdata = rker;
      SEL_RKCS: o_reg_rdata = rkcs_rd;
      SEL_RKWC: o_reg_rdata = rkwc;
      SEL_RKBA: o_reg_rdata = rkba;
      SEL_RKDA: o_reg_rdata = rkda;
      default:  o_reg_rdata = '0;
    endcase
  end

  // Rotating sector counter reported in RKDS
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sc_div <= '0;
      sector <= '0;
    end else if (sc_div == SC_LAST) begin
      sc_div <= '0;
      sector <= (sector == 4'(MAX_SECT)) ? 4'd0 : sector + 4'd1;
    end else begin
      sc_div <= sc_div + 1'b1;
    end
  end

  // Register file, interrupt flag and command sequencer
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state                <= ST_IDLE;
      func                 <= '0;
      mex                  <= '0;
      ide                  <= 1'b0;
      rdy                  <= 1'b1;
      rker                 <= '0;
      rkwc                 <= '0;
      rkba                 <= '0;
      rkda                 <= '0;
      last_drive           <= '0;
      to_cnt               <= '0;
      o_irq                <= 1'b0;
      o_disk_read          <= 1'b0;
      o_disk_write         <= 1'b0;
      o_disk_seek          <= 1'b0;
      o_disk_block_address <= '0;
    end else begin
      if (i_irq_ack) o_irq <= 1'b0;

      // While busy only IDE is writable; everything else waits for RDY
      if (i_reg_wr) begin
        case (i_reg_sel)
          SEL_RKCS: begin
            ide <= i_reg_wdata[6];
            if (!i_reg_wdata[6]) o_irq <= 1'b0;
            if (rdy) begin
              func <= i_reg_wdata[3:1];
              mex  <= i_reg_wdata[5:4];
              if (i_reg_wdata[6] && !i_reg_wdata[0]) o_irq <= 1'b1;
            end
          end
          SEL_RKWC: if (rdy) rkwc <= i_reg_wdata;
          SEL_RKBA: if (rdy) rkba <= i_reg_wdata;
          SEL_RKDA: if (rdy) rkda <= i_reg_wdata;
          default: ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (go_wr) begin
            rdy   <= 1'b0;
            rker  <= '0;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          last_drive <= rkda[15:13];
          if (func == FN_CTRL_RESET) begin
            rker  <= '0;
            rkwc  <= '0;
            rkba  <= '0;
            rkda  <= '0;
            mex   <= '0;
            state <= ST_DONE;
          end else if (func == FN_WRITE_CHECK || func == FN_READ_CHECK ||
                       func == FN_WRITE_LOCK) begin
            state <= ST_DONE;
          end else if (nxs || nxc || nxd) begin
            rker[RKER_NXS] <= nxs;
            rker[RKER_NXC] <= nxc;
            rker[RKER_NXD] <= nxd;
            state          <= ST_DONE;
          end else if (wp_hit) begin
            rker[RKER_WLO] <= 1'b1;
            state          <= ST_DONE;
          end else begin
            o_disk_block_address <= chs_block;
            o_disk_read          <= (func == FN_READ);
            o_disk_write         <= (func == FN_WRITE);
            o_disk_seek          <= (func == FN_SEEK) || (func == FN_DRIVE_RESET);
            state                <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!i_disk_ready) begin
            o_disk_read  <= 1'b0;
            o_disk_write <= 1'b0;
            o_disk_seek  <= 1'b0;
            to_cnt       <= '0;
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (i_sd_error != 4'd0) begin
            rker[RKER_DRE] <= 1'b1;
            state          <= ST_DONE;
          end else if (i_disk_ready) begin
            state <= ST_DONE;
          end else if (to_cnt == TO_LAST) begin
            rker[RKER_DRE] <= 1'b1;
            state          <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          rdy <= 1'b1;
          if ((func == FN_READ || func == FN_WRITE) && (rker == 16'd0)) begin
            mex  <= dma_next[17:16];
            rkba <= dma_next[15:0];
            rkwc <= '0;
          end
          if (ide) o_irq <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rk11_ctrl.sv
// Directed bench for rk11_ctrl: register table plus hand-written command
// sequences. Define RK_WRITE_PROTECT_EN to exercise the write-protect build.
module tb_rk11_ctrl;
  import rk11_pkg::*;

  localparam int TIMEOUT_CYC = 200;
  localparam int SECTOR_CYC  = 8;

  logic        clk;
  logic        rst_n;
  logic [2:0]  reg_sel;
  logic        reg_wr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        irq;
  logic        irq_ack;
  logic        disk_read, disk_write, disk_seek;
  logic [23:0] block_addr;
  logic [17:0] dma_addr;
  logic [15:0] dma_wc;
  logic        disk_ready;
  logic [3:0]  sd_error;
  rk_state_e   dbg_state;
`ifdef RK_WRITE_PROTECT_EN
  logic [0:0]  write_protect;
`endif

  int tests;
  int fails;

  rk11_ctrl #(
    .DMA_MSB        (17),
    .NUM_DRIVES     (1),
    .BLOCKS_PER_DRV (4872),
    .TIMEOUT_CYC    (TIMEOUT_CYC),
    .SECTOR_CYC     (SECTOR_CYC)
  ) dut (
    .i_clk                (clk),
    .i_reset_n            (rst_n),
    .i_reg_sel            (reg_sel),
    .i_reg_wr             (reg_wr),
    .i_reg_wdata          (reg_wdata),
    .o_reg_rdata          (reg_rdata),
    .o_irq                (irq),
    .i_irq_ack            (irq_ack),
    .o_disk_read          (disk_read),
    .o_disk_write         (disk_write),
    .o_disk_seek          (disk_seek),
    .o_disk_block_address (block_addr),
    .o_dma_start_address  (dma_addr),
    .o_dma_wordcount      (dma_wc),
    .i_disk_ready         (disk_ready),
    .i_sd_error           (sd_error),
`ifdef RK_WRITE_PROTECT_EN
    .i_write_protect      (write_protect),
`endif
    .o_dbg_state          (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  sel;
    logic [15:0] wdata;
    logic [15:0] exp;
    logic [15:0] mask;
  } reg_vec_t;

  typedef struct {
    logic [15:0] rkda;
    logic [15:0] exp_rker;
  } addr_vec_t;

  reg_vec_t  rvec[15];
  addr_vec_t avec[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] sel, input logic [15:0] data);
    @(negedge clk);
    reg_sel   = sel;
    reg_wdata = data;
    reg_wr    = 1'b1;
    @(negedge clk);
    reg_wr    = 1'b0;
    #1;
  endtask

  task automatic read_reg(input logic [2:0] sel, output logic [15:0] data);
    reg_sel = sel;
    #1;
    data = reg_rdata;
  endtask

  task automatic check_reg(input string name, input logic [2:0] sel, input logic [15:0] exp);
    logic [15:0] d;
    read_reg(sel, d);
    check(name, d, exp);
  endtask

  // Wait for RKCS.RDY with a cycle budget
  task automatic wait_rdy(input string name, input int max_cyc);
    logic [15:0] d;
    int n;
    n = 0;
    read_reg(SEL_RKCS, d);
    while (!d[7] && n < max_cyc) begin
      @(negedge clk);
      read_reg(SEL_RKCS, d);
      n++;
    end
    check({name, "_rdy"}, d[7], 1'b1);
  endtask

  // Wait for a request, check which line and address, then accept it
  task automatic accept_req(input string name, input logic [2:0] exp_rws, input logic [23:0] exp_blk);
    int n;
    n = 0;
    #1;
    while (!(disk_read | disk_write | disk_seek) && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_req"}, {disk_read, disk_write, disk_seek}, exp_rws);
    check({name, "_blk"}, block_addr, exp_blk);
    repeat (2) @(negedge clk);
    #1;
    check({name, "_hold"}, {disk_read, disk_write, disk_seek}, exp_rws);
    disk_ready = 1'b0;
    @(negedge clk);
    #1;
    check({name, "_drop"}, {disk_read, disk_write, disk_seek}, 3'b000);
  endtask

  // Run to RDY, flagging any disk request seen on the way
  task automatic expect_no_req(input string name);
    logic seen;
    logic [15:0] d;
    int n;
    seen = 1'b0;
    n = 0;
    read_reg(SEL_RKCS, d);
    while (!d[7] && n < 20) begin
      seen |= disk_read | disk_write | disk_seek;
      @(negedge clk);
      read_reg(SEL_RKCS, d);
      n++;
    end
    seen |= disk_read | disk_write | disk_seek;
    check({name, "_noreq"}, seen, 1'b0);
    check({name, "_rdy"}, d[7], 1'b1);
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0]  max_sect;
    logic        wrapped;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    reg_sel = '0;
    reg_wr = 1'b0;
    reg_wdata = '0;
    irq_ack = 1'b0;
    disk_ready = 1'b1;
    sd_error = '0;
`ifdef RK_WRITE_PROTECT_EN
    write_protect = 1'b0;
`endif

    rvec[0]  = '{1'b0, SEL_RKCS, 16'h0000, 16'h0080, 16'hFFFF};
    rvec[1]  = '{1'b0, SEL_RKDS, 16'h0000, 16'h09C0, 16'hFFF0};
    rvec[2]  = '{1'b0, SEL_RKER, 16'h0000, 16'h0000, 16'hFFFF};
    rvec[3]  = '{1'b0, SEL_RKWC, 16'h0000, 16'h0000, 16'hFFFF};
    rvec[4]  = '{1'b0, SEL_RKBA, 16'h0000, 16'h0000, 16'hFFFF};
    rvec[5]  = '{1'b0, SEL_RKDA, 16'h0000, 16'h0000, 16'hFFFF};
    rvec[6]  = '{1'b0, 3'd6,     16'h0000, 16'h0000, 16'hFFFF};
    rvec[7]  = '{1'b0, 3'd7,     16'h0000, 16'h0000, 16'hFFFF};
    rvec[8]  = '{1'b1, SEL_RKWC, 16'hFF00, 16'hFF00, 16'hFFFF};
    rvec[9]  = '{1'b1, SEL_RKBA, 16'h0200, 16'h0200, 16'hFFFF};
    rvec[10] = '{1'b1, SEL_RKDA, 16'h0027, 16'h0027, 16'hFFFF};
    rvec[11] = '{1'b1, SEL_RKCS, 16'h0034, 16'h00B4, 16'hFFFF};
    rvec[12] = '{1'b1, SEL_RKER, 16'hFFFF, 16'h0000, 16'hFFFF};
    rvec[13] = '{1'b1, SEL_RKDS, 16'hFFFF, 16'h09C0, 16'hFFF0};
    rvec[14] = '{1'b1, SEL_RKCS, 16'h0004, 16'h0084, 16'hFFFF};

    avec[0] = '{16'h000D, 16'h0020};  // sector 13
    avec[1] = '{16'h000C, 16'h0020};  // sector 12
    avec[2] = '{16'h1960, 16'h0040};  // cylinder 203
    avec[3] = '{16'h2000, 16'h0080};  // drive 1

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_irq", irq, 1'b0);
    check("rst_req", {disk_read, disk_write, disk_seek}, 3'b000);
    check("rst_dma", dma_addr, 18'h0);

    // Register table
    for (int i = 0; i < 15; i++) begin
      if (rvec[i].wr) write_reg(rvec[i].sel, rvec[i].wdata);
      read_reg(rvec[i].sel, d);
      check($sformatf("reg_vec%0d", i), d & rvec[i].mask, rvec[i].exp);
    end

    // Read: RKDA 0o47, RKWC -256, RKBA 0o1000 -> block 31, RKBA 0o2000
    write_reg(SEL_RKCS, 16'h0005);
    check("rd_busy_cs", reg_rdata[7], 1'b0);
    accept_req("rd", 3'b100, 24'd31);
    check("rd_dma_wc", dma_wc, 16'hFF00);
    disk_ready = 1'b1;
    wait_rdy("rd", 10);
    check_reg("rd_rkwc", SEL_RKWC, 16'h0000);
    check_reg("rd_rkba", SEL_RKBA, 16'h0400);
    check_reg("rd_rkcs", SEL_RKCS, 16'h0084);
    check("rd_irq", irq, 1'b0);

    // Write crossing 64 KiB: RKBA 0o177000, RKWC -512 -> MEX 1, RKBA 0o1000
    write_reg(SEL_RKBA, 16'hFE00);
    write_reg(SEL_RKWC, 16'hFE00);
    write_reg(SEL_RKCS, 16'h0003);
    accept_req("wr", 3'b010, 24'd31);
    disk_ready = 1'b1;
    wait_rdy("wr", 10);
    check_reg("wr_rkcs", SEL_RKCS, 16'h0092);
    check_reg("wr_rkba", SEL_RKBA, 16'h0200);
    check("wr_dma", dma_addr, 18'h10200);

    // Zero word count read leaves RKBA alone
    write_reg(SEL_RKBA, 16'h0140);
    write_reg(SEL_RKCS, 16'h0015);
    accept_req("wc0", 3'b100, 24'd31);
    disk_ready = 1'b1;
    wait_rdy("wc0", 10);
    check_reg("wc0_rkba", SEL_RKBA, 16'h0140);
    check_reg("wc0_rker", SEL_RKER, 16'h0000);

    // Address errors: no request, error bit, ERR and HE set
    for (int i = 0; i < 4; i++) begin
      write_reg(SEL_RKDA, avec[i].rkda);
      write_reg(SEL_RKCS, 16'h0005);
      expect_no_req($sformatf("aerr%0d", i));
      check_reg($sformatf("aerr%0d_rker", i), SEL_RKER, avec[i].exp_rker);
      read_reg(SEL_RKCS, d);
      check($sformatf("aerr%0d_errhe", i), d[15:14], 2'b11);
    end
    read_reg(SEL_RKDS, d);
    check("rkds_drive", d[15:13], 3'd1);

    // Last valid sector on last cylinder, surface 1, seek: block 4871
    write_reg(SEL_RKWC, 16'hFFF0);
    write_reg(SEL_RKDA, 16'h195B);
    write_reg(SEL_RKCS, 16'h0009);
    accept_req("sk", 3'b001, 24'd4871);
    disk_ready = 1'b1;
    wait_rdy("sk", 10);
    check_reg("sk_rkwc", SEL_RKWC, 16'hFFF0);
    check_reg("sk_rker", SEL_RKER, 16'h0000);

    // sdhd error with IDE set: DRE, interrupt, acknowledge clears it
    write_reg(SEL_RKCS, 16'h0045);
    accept_req("sde", 3'b100, 24'd4871);
    sd_error = 4'd4;
    @(negedge clk);
    sd_error = 4'd0;
    disk_ready = 1'b1;
    wait_rdy("sde", 10);
    check_reg("sde_rker", SEL_RKER, 16'h8000);
    check_reg("sde_rkwc", SEL_RKWC, 16'hFFF0);
    check("sde_irq", irq, 1'b1);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    #1;
    check("sde_ack", irq, 1'b0);

    // Interrupt from setting IDE while ready, cleared by writing IDE=0
    write_reg(SEL_RKCS, 16'h0040);
    check("ide_set_irq", irq, 1'b1);
    write_reg(SEL_RKCS, 16'h0000);
    check("ide_clr_irq", irq, 1'b0);

    // Timeout while busy; RKWC write during BUSY is ignored
    write_reg(SEL_RKWC, 16'hFF00);
    write_reg(SEL_RKCS, 16'h0005);
    accept_req("to", 3'b100, 24'd4871);
    write_reg(SEL_RKWC, 16'h1234);
    check_reg("to_rkwc_busy", SEL_RKWC, 16'hFF00);
    repeat (100) @(negedge clk);
    read_reg(SEL_RKCS, d);
    check("to_not_early", d[7], 1'b0);
    wait_rdy("to", 3 * TIMEOUT_CYC);
    check_reg("to_rker", SEL_RKER, 16'h8000);
    check_reg("to_rkwc", SEL_RKWC, 16'hFF00);
    disk_ready = 1'b1;

    // Control reset function clears the register file
    write_reg(SEL_RKBA, 16'h1111);
    write_reg(SEL_RKDA, 16'h0027);
    write_reg(SEL_RKCS, 16'h0031);
    expect_no_req("crst");
    check_reg("crst_rkcs", SEL_RKCS, 16'h0080);
    check_reg("crst_rkwc", SEL_RKWC, 16'h0000);
    check_reg("crst_rkba", SEL_RKBA, 16'h0000);
    check_reg("crst_rkda", SEL_RKDA, 16'h0000);

    // Reset in the middle of a request
    write_reg(SEL_RKDA, 16'h0027);
    write_reg(SEL_RKCS, 16'h0005);
    @(negedge clk);
    #1;
    check("mid_req_up", disk_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_req_drop", disk_read, 1'b0);
    check("mid_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    check_reg("mid_rkcs", SEL_RKCS, 16'h0080);
    check_reg("mid_rkda", SEL_RKDA, 16'h0000);

`ifdef RK_WRITE_PROTECT_EN
    write_protect = 1'b1;
    write_reg(SEL_RKCS, 16'h0003);
    expect_no_req("wp");
    check_reg("wp_rker", SEL_RKER, 16'h2000);
    write_protect = 1'b0;
`endif

    // Sector counter stays within 0..11 and wraps
    max_sect = '0;
    wrapped = 1'b0;
    reg_sel = SEL_RKDS;
    for (int i = 0; i < 14 * SECTOR_CYC; i++) begin
      @(negedge clk);
      #1;
      if (reg_rdata[3:0] > max_sect) max_sect = reg_rdata[3:0];
      if (max_sect == 4'd11 && reg_rdata[3:0] == 4'd0) wrapped = 1'b1;
    end
    check("sect_max", max_sect, 4'd11);
    check("sect_wrap", wrapped, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
